// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/memory requesters, issue logic and the register-file write port.
// The arbiter takes the slave view; the producers and the register file take the master view.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic                   alu_valid;
   logic [ADDR_W-1:0]      alu_dst;
   logic [DATA_W-1:0]      alu_data;
   logic                   alu_ready;
   logic                   mem_valid;
   logic [ADDR_W-1:0]      mem_dst;
   logic [DATA_W-1:0]      mem_data;
   logic                   mem_ready;
   logic                   issue_valid;
   logic [ADDR_W-1:0]      issue_dst;
   logic [2**ADDR_W-1:0]   pending;
   logic [ADDR_W-1:0]      DstReg;
   logic [DATA_W-1:0]      DstData;
   logic                   WriteReg;

   modport slave (
      input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
             issue_valid, issue_dst,
      output alu_ready, mem_ready, pending, DstReg, DstData, WriteReg
   );

   modport master (
      output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
             issue_valid, issue_dst,
      input  alu_ready, mem_ready, pending, DstReg, DstData, WriteReg
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port, registers the
// winning write, and tracks outstanding destination registers for RAW hazard detection.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   regfile_wb_arbiter_if.slave bus_if
);
   localparam int NREG = 2**ADDR_W;

   logic [2:0]        starve_q, starve_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NREG-1:0]   pending_q, pending_d;
   logic              alu_gnt, mem_gnt;

   // MEM wins contention until the ALU has lost STARVE_MAX times in a row.
   always_comb begin
      alu_gnt = bus_if.alu_valid && (!bus_if.mem_valid || starve_q == 3'(STARVE_MAX));
      mem_gnt = bus_if.mem_valid && !alu_gnt;
   end

   always_comb begin
      starve_d = starve_q;
      if (!bus_if.alu_valid || alu_gnt)
         starve_d = 3'd0;
      else if (mem_gnt)
         starve_d = starve_q + 3'd1;
   end

   // r0 is hardwired zero: the request is still accepted but never reaches the port.
   always_comb begin
      wr_en_d = 1'b0;
      dst_d   = dst_q;
      data_d  = data_q;
      if (alu_gnt && bus_if.alu_dst != '0) begin
         wr_en_d = 1'b1;
         dst_d   = bus_if.alu_dst;
         data_d  = bus_if.alu_data;
      end else if (mem_gnt && bus_if.mem_dst != '0) begin
         wr_en_d = 1'b1;
         dst_d   = bus_if.mem_dst;
         data_d  = bus_if.mem_data;
      end
   end

   // Set after clear so a newly issued producer keeps the bit alive on the retiring edge.
   always_comb begin
      pending_d = pending_q;
      if (wr_en_q)
         pending_d[dst_q] = 1'b0;
      if (bus_if.issue_valid && bus_if.issue_dst != '0)
         pending_d[bus_if.issue_dst] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q  <= 3'd0;
         wr_en_q   <= 1'b0;
         dst_q     <= '0;
         data_q    <= '0;
         pending_q <= '0;
      end else begin
         starve_q  <= starve_d;
         wr_en_q   <= wr_en_d;
         dst_q     <= dst_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   assign bus_if.alu_ready = alu_gnt;
   assign bus_if.mem_ready = mem_gnt;
   assign bus_if.WriteReg  = wr_en_q;
   assign bus_if.DstReg    = dst_q;
   assign bus_if.DstData   = data_q;
   assign bus_if.pending   = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: each driven cycle pushes its expected write,
// which is popped and compared one clock later.
module tb_regfile_wb_arbiter;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) rf_if ();
   regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .STARVE_MAX(3)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus_if(rf_if)
   );

   typedef struct {
      logic        we;
      logic [3:0]  dst;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          m_starve = 0;
   logic [15:0] m_pend = '0;
   logic        m_we = 1'b0;
   logic [3:0]  m_dst = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_starve = 0;
      m_pend   = '0;
      m_we     = 1'b0;
      m_dst    = '0;
   endtask

   task automatic idle_inputs();
      rf_if.alu_valid = 1'b0; rf_if.alu_dst = '0; rf_if.alu_data = '0;
      rf_if.mem_valid = 1'b0; rf_if.mem_dst = '0; rf_if.mem_data = '0;
      rf_if.issue_valid = 1'b0; rf_if.issue_dst = '0;
   endtask

   // Called at a falling edge; drives one cycle, checks readies, then checks the write stage.
   task automatic step(input logic av, input logic [3:0] ad, input logic [15:0] adat,
                       input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                       input logic iv, input logic [3:0] id,
                       output logic ga, output logic gm);
      wr_t         e, o;
      logic [15:0] nxt;
      rf_if.alu_valid = av; rf_if.alu_dst = ad; rf_if.alu_data = adat;
      rf_if.mem_valid = mv; rf_if.mem_dst = md; rf_if.mem_data = mdat;
      rf_if.issue_valid = iv; rf_if.issue_dst = id;
      #1;
      ga = av && (!mv || m_starve == 3);
      gm = mv && !ga;
      chk("alu_ready", 32'(rf_if.alu_ready), 32'(ga));
      chk("mem_ready", 32'(rf_if.mem_ready), 32'(gm));
      chk("ready_excl", 32'(rf_if.alu_ready & rf_if.mem_ready), 32'd0);
      e.we   = (ga && ad != 4'd0) || (gm && md != 4'd0);
      e.dst  = ga ? ad : md;
      e.data = ga ? adat : mdat;
      exp_q.push_back(e);
      if (!av || ga) m_starve = 0;
      else if (gm) m_starve++;
      nxt = m_pend;
      if (m_we) nxt[m_dst] = 1'b0;
      if (iv && id != 4'd0) nxt[id] = 1'b1;
      m_pend = nxt;
      m_we = e.we;
      if (e.we) m_dst = e.dst;
      @(posedge clk_i);
      @(negedge clk_i);
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd1, 32'd0);
      end else begin
         o = exp_q.pop_front();
         chk("WriteReg", 32'(rf_if.WriteReg), 32'(o.we));
         if (o.we) begin
            chk("DstReg", 32'(rf_if.DstReg), 32'(o.dst));
            chk("DstData", 32'(rf_if.DstData), 32'(o.data));
         end
      end
      chk("pending", 32'(rf_if.pending), 32'(m_pend));
   endtask

   initial begin
      logic        ga, gm;
      logic        rav, rmv;
      logic [3:0]  rad, rmd;
      logic [15:0] radat, rmdat;
      idle_inputs();
      repeat (2) @(negedge clk_i);
      chk("rst_WriteReg", 32'(rf_if.WriteReg), 32'd0);
      chk("rst_DstReg", 32'(rf_if.DstReg), 32'd0);
      chk("rst_DstData", 32'(rf_if.DstData), 32'd0);
      chk("rst_pending", 32'(rf_if.pending), 32'd0);
      rst_ni = 1'b1;

      // Lone ALU write
      step(1, 4'd5, 16'h1234, 0, 0, 0, 0, 0, ga, gm);
      chk("lone_alu_data", 32'(rf_if.DstData), 32'h1234);

      // Build starve count, then reset mid-stream with a write in flight and pending bits set
      step(1, 4'd2, 16'h0002, 1, 4'd9, 16'h0009, 1, 4'd12, ga, gm);
      step(1, 4'd2, 16'h0002, 1, 4'd9, 16'h0019, 0, 0, ga, gm);
      rf_if.mem_valid = 1'b1; rf_if.mem_dst = 4'd9; rf_if.mem_data = 16'h0029;
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_WriteReg", 32'(rf_if.WriteReg), 32'd0);
      chk("midrst_pending", 32'(rf_if.pending), 32'd0);
      model_reset();
      idle_inputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

      // Contention: ALU holds its request until granted; MEM presents fresh data each cycle
      rad = 4'd1; radat = 16'hA000;
      for (int i = 0; i < 8; i++) begin
         step(1, rad, radat, 1, 4'(8 + i), 16'(16'hB000 + i), 0, 0, ga, gm);
         chk("contention_gnt", 32'(ga), 32'((i % 4) == 3));
         if (ga) begin rad = rad + 4'd1; radat = radat + 16'd1; end
      end

      // r0 writes are accepted but dropped; issuing r0 never sets pending[0]
      step(0, 0, 0, 1, 4'd0, 16'hDEAD, 1, 4'd0, ga, gm);
      chk("r0_mem_ready", 32'(gm), 32'd1);
      step(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
      chk("r0_pending0", 32'(rf_if.pending[0]), 32'd0);

      // Scoreboard: set, retire, and re-issue on the retiring edge
      step(0, 0, 0, 0, 0, 0, 1, 4'd7, ga, gm);
      chk("pend7_set", 32'(rf_if.pending[7]), 32'd1);
      step(1, 4'd7, 16'h0777, 0, 0, 0, 0, 0, ga, gm);
      step(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
      chk("pend7_clr", 32'(rf_if.pending[7]), 32'd0);
      step(0, 0, 0, 0, 0, 0, 1, 4'd7, ga, gm);
      step(1, 4'd7, 16'h0778, 0, 0, 0, 0, 0, ga, gm);
      step(0, 0, 0, 0, 0, 0, 1, 4'd7, ga, gm);
      chk("pend7_setwins", 32'(rf_if.pending[7]), 32'd1);

      // Same destination from both: MEM first, then ALU
      step(1, 4'd3, 16'hAAAA, 1, 4'd3, 16'h5555, 0, 0, ga, gm);
      chk("same_dst_first", 32'(rf_if.DstData), 32'h5555);
      step(1, 4'd3, 16'hAAAA, 0, 0, 0, 0, 0, ga, gm);
      chk("same_dst_final", 32'(rf_if.DstData), 32'hAAAA);

      // Random traffic, requests held until accepted
      rav = 0; rmv = 0; rad = 0; rmd = 0; radat = 0; rmdat = 0;
      for (int i = 0; i < 60; i++) begin
         if (!rav && $urandom_range(0, 1) == 1) begin
            rav = 1; rad = 4'($urandom_range(0, 15)); radat = 16'($urandom);
         end
         if (!rmv && $urandom_range(0, 2) != 0) begin
            rmv = 1; rmd = 4'($urandom_range(0, 15)); rmdat = 16'($urandom);
         end
         step(rav, rad, radat, rmv, rmd, rmdat, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), ga, gm);
         if (ga) rav = 0;
         if (gm) rmv = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
